grf_write_arbiter: RTL and testbench

- Shares the single GRF write port between two producers: the pipeline write-back stage (port A, priority, no backpressure) and the long-latency multiply/divide result path (port B, valid/ready).
- B results that lose arbitration go into a small in-order FIFO.
- Provides pending-write "busy" lookups for the hazard unit.
- Requests a one-cycle pipeline stall when buffered B results have been starved too long.
- Sits between the W-stage/MDU and the GRF write inputs.

---
 rtl/grf_write_arbiter_if.sv | 43 ++++
 rtl/grf_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_grf_write_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_write_arbiter_if.sv
// GRF write arbiter port bundle: write-back port A, MDU port B (valid/ready),
// hazard busy queries, stall request, FIFO occupancy and the GRF write port.
interface grf_write_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          a_we;
   logic [4:0]    a_aw;
   logic [31:0]   a_wd;
   logic [31:0]   a_pc;
   logic          b_valid;
   logic          b_ready;
   logic [4:0]    b_aw;
   logic [31:0]   b_wd;
   logic [31:0]   b_pc;
   logic [4:0]    q_a1;
   logic [4:0]    q_a2;
   logic          q_busy1;
   logic          q_busy2;
   logic          stall_req;
   logic [CW-1:0] fifo_count;
   logic          regWE;
   logic [4:0]    regAW;
   logic [31:0]   regWD;
   logic [31:0]   pc;

   modport master (
      output a_we, a_aw, a_wd, a_pc,
      output b_valid, b_aw, b_wd, b_pc,
      output q_a1, q_a2,
      input  b_ready, q_busy1, q_busy2, stall_req, fifo_count,
      input  regWE, regAW, regWD, pc
   );

   modport slave (
      input  a_we, a_aw, a_wd, a_pc,
      input  b_valid, b_aw, b_wd, b_pc,
      input  q_a1, q_a2,
      output b_ready, q_busy1, q_busy2, stall_req, fifo_count,
      output regWE, regAW, regWD, pc
   );
endinterface

// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: port A (write-back, priority) vs port B (MDU, FIFO
// buffered), busy lookups and starvation stall. Ports: clk, reset (async
// active-low), bus (grf_write_arbiter_if.slave). Optional: GRF_ARB_DISPLAY_EN
// prints every committed write.
module grf_write_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input logic                clk,
   input logic                reset,
   grf_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_FIFO,
      SEL_A,
      SEL_B
   } sel_e;

   logic [4:0]       f_aw [DEPTH];
   logic [31:0]      f_wd [DEPTH];
   logic [31:0]      f_pc [DEPTH];
   logic [DEPTH-1:0] f_vld;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [WW-1:0]    wait_cnt;
   logic [WW-1:0]    wait_nxt;
   logic             stall_q;

   logic empty;
   logic ready;
   logic b_live;
   logic a_act;
   logic push;
   logic pop;
   sel_e sel;
   logic hit1;
   logic hit2;

   always_comb begin
      empty  = (count == '0);
      ready  = reset & (count < FULL);
      b_live = bus.b_valid & ready & (bus.b_aw != 5'd0);
      a_act  = bus.a_we & (bus.a_aw != 5'd0) & ~stall_q;
      sel    = SEL_NONE;
      push   = 1'b0;
      pop    = 1'b0;
      if (reset) begin
         if (stall_q && !empty) begin
            sel  = SEL_FIFO;
            pop  = 1'b1;
            push = b_live;
         end else if (a_act) begin
            sel  = SEL_A;
            push = b_live;
         end else if (!empty) begin
            sel  = SEL_FIFO;
            pop  = 1'b1;
            push = b_live;
         end else if (b_live) begin
            // empty FIFO: B goes straight to the GRF
            sel  = SEL_B;
         end
      end
   end

   always_comb begin
      bus.regWE = 1'b0;
      bus.regAW = 5'd0;
      bus.regWD = 32'd0;
      bus.pc    = 32'd0;
      unique case (sel)
         SEL_FIFO: begin
            bus.regWE = 1'b1;
            bus.regAW = f_aw[rd_ptr];
            bus.regWD = f_wd[rd_ptr];
            bus.pc    = f_pc[rd_ptr];
         end
         SEL_A: begin
            bus.regWE = 1'b1;
            bus.regAW = bus.a_aw;
            bus.regWD = bus.a_wd;
            bus.pc    = bus.a_pc;
         end
         SEL_B: begin
            bus.regWE = 1'b1;
            bus.regAW = bus.b_aw;
            bus.regWD = bus.b_wd;
            bus.pc    = bus.b_pc;
         end
         default: ;
      endcase
   end

   // entries being popped stay busy; GRF shows the value next cycle
   always_comb begin
      hit1 = bus.b_valid & (bus.b_aw == bus.q_a1);
      hit2 = bus.b_valid & (bus.b_aw == bus.q_a2);
      for (int i = 0; i < DEPTH; i++) begin
         if (f_vld[i] && f_aw[i] == bus.q_a1) hit1 = 1'b1;
         if (f_vld[i] && f_aw[i] == bus.q_a2) hit2 = 1'b1;
      end
      bus.q_busy1 = reset & (bus.q_a1 != 5'd0) & hit1;
      bus.q_busy2 = reset & (bus.q_a2 != 5'd0) & hit2;
   end

   always_comb begin
      if (empty || pop) wait_nxt = '0;
      else if (a_act && wait_cnt != WMAX) wait_nxt = wait_cnt + WW'(1);
      else wait_nxt = wait_cnt;
   end

   assign bus.b_ready    = ready;
   assign bus.fifo_count = count;
   assign bus.stall_req  = stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         f_vld    <= '0;
         wait_cnt <= '0;
         stall_q  <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr        <= rd_ptr + PW'(1);
            f_vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr        <= wr_ptr + PW'(1);
            f_vld[wr_ptr] <= 1'b1;
         end
         count    <= count + CW'(push) - CW'(pop);
         wait_cnt <= wait_nxt;
         // single-cycle pulse; the stall cycle pops and clears the counter
         stall_q  <= (wait_nxt == WMAX) & ~stall_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         f_aw[wr_ptr] <= bus.b_aw;
         f_wd[wr_ptr] <= bus.b_wd;
         f_pc[wr_ptr] <= bus.b_pc;
      end
   end

`ifdef GRF_ARB_DISPLAY_EN
   always @(posedge clk) begin
      if (reset && bus.regWE)
         $display("@%h: $%d <= %h", bus.pc, bus.regAW, bus.regWD);
   end
`else
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: scoreboard of expected GRF
// writes plus per-scenario inline checks.
module tb_grf_write_arbiter;
   typedef struct packed {
      logic [4:0]  aw;
      logic [31:0] wd;
      logic [31:0] pc;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   wr_t  sb[$];

   grf_write_arbiter_if #(.DEPTH(4)) bus();

   grf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // every committed write must be the next expected one
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.regWE === 1'b1) begin
         wr_t got;
         wr_t exp;
         got = '{aw: bus.regAW, wd: bus.regWD, pc: bus.pc};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got %h expected no write", got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               failures++;
               $display("FAIL sb_write: got %h expected %h", got, exp);
            end
         end
      end
   end

   task automatic idle();
      bus.a_we = 0; bus.a_aw = 0; bus.a_wd = 0; bus.a_pc = 0;
      bus.b_valid = 0; bus.b_aw = 0; bus.b_wd = 0; bus.b_pc = 0;
      bus.q_a1 = 0; bus.q_a2 = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 0;
      bus.a_we = 1; bus.a_aw = 3;
      bus.b_valid = 1; bus.b_aw = 4; bus.q_a1 = 4;
      @(negedge clk);
      checks++;
      if (bus.regWE !== 1'b0) begin
         failures++; $display("FAIL rst_we: got %b expected 0", bus.regWE);
      end
      checks++;
      if (bus.b_ready !== 1'b0) begin
         failures++; $display("FAIL rst_ready: got %b expected 0", bus.b_ready);
      end
      checks++;
      if (bus.fifo_count !== 3'd0) begin
         failures++; $display("FAIL rst_count: got %0d expected 0", bus.fifo_count);
      end
      checks++;
      if (bus.stall_req !== 1'b0) begin
         failures++; $display("FAIL rst_stall: got %b expected 0", bus.stall_req);
      end
      checks++;
      if (bus.q_busy1 !== 1'b0) begin
         failures++; $display("FAIL rst_busy: got %b expected 0", bus.q_busy1);
      end
      idle();
      step();
      reset = 1;
      @(negedge clk);
      checks++;
      if (bus.b_ready !== 1'b1) begin
         failures++; $display("FAIL rst_rel_ready: got %b expected 1", bus.b_ready);
      end
      step();
   endtask

   task automatic test_a_with_b();
      bus.a_we = 1; bus.a_aw = 5; bus.a_wd = 32'h11; bus.a_pc = 32'h1000;
      bus.b_valid = 1; bus.b_aw = 6; bus.b_wd = 32'h22; bus.b_pc = 32'h2000;
      bus.q_a1 = 6; bus.q_a2 = 5;
      sb.push_back('{aw: 5'd5, wd: 32'h11, pc: 32'h1000});
      sb.push_back('{aw: 5'd6, wd: 32'h22, pc: 32'h2000});
      @(negedge clk);
      checks++;
      if (bus.q_busy1 !== 1'b1 || bus.q_busy2 !== 1'b0) begin
         failures++;
         $display("FAIL ab_busy: got %b%b expected 10", bus.q_busy1, bus.q_busy2);
      end
      step();
      bus.a_we = 0; bus.b_valid = 0;
      @(negedge clk);
      checks++;
      if (bus.fifo_count !== 3'd1) begin
         failures++; $display("FAIL ab_count1: got %0d expected 1", bus.fifo_count);
      end
      checks++;
      if (bus.q_busy1 !== 1'b1) begin
         failures++; $display("FAIL ab_busy_pop: got %b expected 1", bus.q_busy1);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.fifo_count !== 3'd0 || bus.q_busy1 !== 1'b0) begin
         failures++;
         $display("FAIL ab_drained: got %0d/%b expected 0/0", bus.fifo_count, bus.q_busy1);
      end
      idle();
      step();
   endtask

   task automatic test_bypass();
      bus.b_valid = 1; bus.b_aw = 7; bus.b_wd = 32'h33; bus.b_pc = 32'h3000;
      sb.push_back('{aw: 5'd7, wd: 32'h33, pc: 32'h3000});
      @(negedge clk);
      checks++;
      if (bus.regWE !== 1'b1 || bus.regAW !== 5'd7 || bus.pc !== 32'h3000) begin
         failures++;
         $display("FAIL byp_out: got %b/%0d/%h expected 1/7/3000", bus.regWE, bus.regAW, bus.pc);
      end
      step();
      bus.b_valid = 0;
      @(negedge clk);
      checks++;
      if (bus.fifo_count !== 3'd0 || bus.regWE !== 1'b0) begin
         failures++;
         $display("FAIL byp_after: got %0d/%b expected 0/0", bus.fifo_count, bus.regWE);
      end
      idle();
      step();
   endtask

   task automatic test_fifo_full();
      int k = 0;
      logic hs;
      bus.q_a1 = 8; bus.q_a2 = 13;
      for (int c = 0; c < 12; c++) begin
         bus.a_we = (c < 6); bus.a_aw = 1;
         bus.a_wd = 32'h100 + c; bus.a_pc = 32'h6000 + 4 * c;
         bus.b_valid = (k < 5); bus.b_aw = 5'(8 + k);
         bus.b_wd = 32'h200 + k; bus.b_pc = 32'h7000 + 4 * k;
         if (c < 6)
            sb.push_back('{aw: 5'd1, wd: 32'h100 + c, pc: 32'h6000 + 4 * c});
         if (c == 6)
            for (int j = 0; j < 5; j++)
               sb.push_back('{aw: 5'(8 + j), wd: 32'h200 + j, pc: 32'h7000 + 4 * j});
         @(negedge clk);
         hs = bus.b_valid & bus.b_ready;
         if (c >= 4 && c <= 6) begin
            checks++;
            if (bus.b_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
               failures++;
               $display("FAIL full_c%0d: got %b/%0d expected 0/4", c, bus.b_ready, bus.fifo_count);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.q_busy1 !== 1'b1 || bus.q_busy2 !== 1'b0) begin
               failures++;
               $display("FAIL full_busy: got %b%b expected 10", bus.q_busy1, bus.q_busy2);
            end
         end
         if (c == 7) begin
            checks++;
            if (bus.b_ready !== 1'b1) begin
               failures++; $display("FAIL full_free: got %b expected 1", bus.b_ready);
            end
         end
         if (c == 11) begin
            checks++;
            if (bus.fifo_count !== 3'd0 || bus.regWE !== 1'b0) begin
               failures++;
               $display("FAIL full_drain: got %0d/%b expected 0/0", bus.fifo_count, bus.regWE);
            end
         end
         step();
         if (hs) k++;
      end
      idle();
   endtask

   task automatic test_starvation();
      for (int c = 0; c < 12; c++) begin
         bus.a_we = (c < 11); bus.a_aw = 2; bus.a_wd = 32'h55; bus.a_pc = 32'h4000;
         bus.b_valid = (c == 0); bus.b_aw = 9; bus.b_wd = 32'h66; bus.b_pc = 32'h5000;
         if (c == 9)
            sb.push_back('{aw: 5'd9, wd: 32'h66, pc: 32'h5000});
         else if (c < 11)
            sb.push_back('{aw: 5'd2, wd: 32'h55, pc: 32'h4000});
         @(negedge clk);
         checks++;
         if (bus.stall_req !== (c == 9)) begin
            failures++;
            $display("FAIL stall_c%0d: got %b expected %b", c, bus.stall_req, (c == 9));
         end
         if (c == 10) begin
            checks++;
            if (bus.fifo_count !== 3'd0) begin
               failures++; $display("FAIL stall_count: got %0d expected 0", bus.fifo_count);
            end
         end
         step();
      end
      idle();
   endtask

   task automatic test_zero_and_reset();
      bus.b_valid = 1; bus.b_aw = 0; bus.b_wd = 32'hdead;
      @(negedge clk);
      checks++;
      if (bus.regWE !== 1'b0 || bus.b_ready !== 1'b1) begin
         failures++;
         $display("FAIL zero_b: got %b/%b expected 0/1", bus.regWE, bus.b_ready);
      end
      step();
      bus.b_valid = 0; bus.a_we = 1; bus.a_aw = 0;
      @(negedge clk);
      checks++;
      if (bus.regWE !== 1'b0 || bus.fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL zero_a: got %b/%0d expected 0/0", bus.regWE, bus.fifo_count);
      end
      step();
      for (int c = 2; c < 6; c++) begin
         bus.a_we = 1; bus.a_aw = 3; bus.a_wd = 32'h300 + c; bus.a_pc = 32'h8000;
         bus.b_valid = (c < 5); bus.b_aw = 5'(8 + c); bus.b_wd = 32'h400 + c;
         bus.q_a1 = 11;
         sb.push_back('{aw: 5'd3, wd: 32'h300 + c, pc: 32'h8000});
         @(negedge clk);
         if (c < 5) step();
      end
      checks++;
      if (bus.fifo_count !== 3'd3 || bus.q_busy1 !== 1'b1) begin
         failures++;
         $display("FAIL zr_fill: got %0d/%b expected 3/1", bus.fifo_count, bus.q_busy1);
      end
      #2 reset = 0;
      #1;
      checks++;
      if (bus.fifo_count !== 3'd0 || bus.regWE !== 1'b0 || bus.q_busy1 !== 1'b0) begin
         failures++;
         $display("FAIL zr_async: got %0d/%b/%b expected 0/0/0", bus.fifo_count, bus.regWE, bus.q_busy1);
      end
      idle();
      bus.q_a1 = 11;
      step();
      reset = 1;
      @(negedge clk);
      checks++;
      if (bus.fifo_count !== 3'd0 || bus.q_busy1 !== 1'b0 || bus.regWE !== 1'b0) begin
         failures++;
         $display("FAIL zr_after: got %0d/%b/%b expected 0/0/0", bus.fifo_count, bus.q_busy1, bus.regWE);
      end
      step();
   endtask

   initial begin
      idle();
      test_reset();
      test_a_with_b();
      test_bypass();
      test_fifo_full();
      test_starvation();
      test_zero_and_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_left: got %0d expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
